// File: rtl/gray_ptr_sync_if.sv
// Pointer bus between an async-FIFO pointer source and its destination-domain synchroniser.
// The master drives the raw Gray pointer and the error clear; the slave returns the synced views.
interface gray_ptr_sync_if #(
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] d_in;
    logic             err_clr;
    logic [PTR_W-1:0] d_out_gray;
    logic [PTR_W-1:0] d_out_bin;
    logic [PTR_W-1:0] delta;
    logic             ready;
    logic             step_err;

    modport master (
        output d_in,
        output err_clr,
        input  d_out_gray,
        input  d_out_bin,
        input  delta,
        input  ready,
        input  step_err
    );

    modport slave (
        input  d_in,
        input  err_clr,
        output d_out_gray,
        output d_out_bin,
        output delta,
        output ready,
        output step_err
    );
endinterface

// File: rtl/gray_ptr_sync.sv
// N-stage synchroniser for Gray-coded FIFO pointers with binary decode, per-cycle advance,
// warm-up ready flag and a sticky flag for multi-bit Gray steps.
module gray_ptr_sync #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    gray_ptr_sync_if.slave  bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(STAGES + 1);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be in the range 2..4");
    end

    function automatic logic [PTR_W-1:0] g2b(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = '0;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_W-1:0] sync_q [STAGES];
    logic [PTR_W-1:0] gray_q;
    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] delta_q;
    logic             ready_q;
    logic             err_q;
    logic [CNT_W-1:0] warm_q;

    logic [PTR_W-1:0] sync_last_c;
    logic [PTR_W-1:0] bin_c;
    logic [PTR_W-1:0] delta_c;
    logic [PTR_W-1:0] diff_c;
    logic             multi_c;

    // Bare flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or posedge rst) begin : p_chain
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.d_in;
            for (int k = 1; k < int'(STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    always_comb begin : p_decode
        sync_last_c = sync_q[STAGES-1];
        bin_c       = g2b(sync_last_c);
        delta_c     = bin_c - bin_q;
        diff_c      = sync_last_c ^ gray_q;
        multi_c     = |(diff_c & (diff_c - PTR_W'(1)));
    end

    // Warm-up: ready rises on the first edge after the chain has flushed reset values.
    always_ff @(posedge clk or posedge rst) begin : p_warm
        if (rst) begin
            warm_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            if (warm_q != CNT_W'(STAGES)) begin
                warm_q <= warm_q + CNT_W'(1);
            end
            ready_q <= ready_q | (warm_q == CNT_W'(STAGES));
        end
    end

    // Output stage; gating on the pre-edge ready keeps the first real sample from
    // being compared against the cleared reset value.
    always_ff @(posedge clk or posedge rst) begin : p_out
        if (rst) begin
            gray_q  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            err_q   <= 1'b0;
        end else begin
            gray_q  <= sync_last_c;
            bin_q   <= bin_c;
            delta_q <= ready_q ? delta_c : '0;
            if (ready_q && multi_c) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.d_out_gray = gray_q;
    assign bus.d_out_bin  = bin_q;
    assign bus.delta      = delta_q;
    assign bus.ready      = ready_q;
    assign bus.step_err   = err_q;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: two instances (2 and 3 stages) share stimulus; a history-based
// model predicts each cycle's outputs into per-instance scoreboards checked by a monitor.
module tb_gray_ptr_sync;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned NPTR   = 2 ** PTR_W;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef struct packed {
        ptr_t gray;
        ptr_t bin;
        ptr_t delta;
        logic ready;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    gray_ptr_sync_if #(.ADDR_W(ADDR_W)) bus2 ();
    gray_ptr_sync_if #(.ADDR_W(ADDR_W)) bus3 ();

    gray_ptr_sync #(.ADDR_W(ADDR_W), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    gray_ptr_sync #(.ADDR_W(ADDR_W), .STAGES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb2[$];
    exp_t sb3[$];
    ptr_t hist[$];        // d_in values captured at each edge since reset release
    ptr_t to_bin[NPTR];
    logic err2 = 1'b0;
    logic err3 = 1'b0;
    int   cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic ptr_t to_gray(input int c);
        ptr_t v;
        v = ptr_t'(c);
        return v ^ (v >> 1);
    endfunction

    // Value on the synced output after edge n (1-based since release) for an s-deep chain.
    function automatic ptr_t gray_at(input int s, input int n);
        if (n >= s + 1) return hist[n-1-s];
        return '0;
    endfunction

    function automatic exp_t predict(input int s, input logic err);
        exp_t e;
        int   n;
        ptr_t g;
        n       = hist.size();
        g       = gray_at(s, n);
        e.gray  = g;
        e.bin   = to_bin[g];
        e.ready = (n >= s + 1);
        e.delta = (n >= s + 2) ? ptr_t'(to_bin[g] - to_bin[gray_at(s, n - 1)]) : '0;
        e.err   = err;
        return e;
    endfunction

    function automatic logic next_err(input int s, input logic err, input logic clr);
        int n;
        n = hist.size();
        if (n >= s + 2 && $countones(gray_at(s, n) ^ gray_at(s, n - 1)) > 1) return 1'b1;
        if (clr) return 1'b0;
        return err;
    endfunction

    // Drive one cycle of inputs, predict the outputs after the coming edge, wait for next negedge.
    task automatic step(input logic r, input ptr_t din, input logic clr);
        rst          = r;
        bus2.d_in    = din;
        bus3.d_in    = din;
        bus2.err_clr = clr;
        bus3.err_clr = clr;
        if (r) begin
            hist.delete();
            err2 = 1'b0;
            err3 = 1'b0;
        end else begin
            hist.push_back(din);
            err2 = next_err(2, err2, clr);
            err3 = next_err(3, err3, clr);
        end
        sb2.push_back(predict(2, err2));
        sb3.push_back(predict(3, err3));
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".s2_outs"}, int'({bus2.d_out_gray, bus2.d_out_bin, bus2.delta, bus2.ready, bus2.step_err}), 0);
        chk({tag, ".s3_outs"}, int'({bus3.d_out_gray, bus3.d_out_bin, bus3.delta, bus3.ready, bus3.step_err}), 0);
    endtask

    task automatic cmp(input string tag, input exp_t e, input ptr_t g, input ptr_t b,
                       input ptr_t d, input logic rdy, input logic er);
        chk({tag, ".gray"},  int'(g),   int'(e.gray));
        chk({tag, ".bin"},   int'(b),   int'(e.bin));
        chk({tag, ".delta"}, int'(d),   int'(e.delta));
        chk({tag, ".ready"}, int'(rdy), int'(e.ready));
        chk({tag, ".err"},   int'(er),  int'(e.err));
    endtask

    // Monitor: one expected entry per instance per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb2.size() == 0 || sb3.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: queue depth got %0d/%0d, want >0", sb2.size(), sb3.size());
            end else begin
                cmp("s2", sb2.pop_front(), bus2.d_out_gray, bus2.d_out_bin, bus2.delta, bus2.ready, bus2.step_err);
                cmp("s3", sb3.pop_front(), bus3.d_out_gray, bus3.d_out_bin, bus3.delta, bus3.ready, bus3.step_err);
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(NPTR); i++) to_bin[to_gray(i)] = ptr_t'(i);

        // Reset with a non-zero pointer present, then warm-up.
        rst          = 1'b1;
        bus2.d_in    = 4'b1010;
        bus3.d_in    = 4'b1010;
        bus2.err_clr = 1'b0;
        bus3.err_clr = 1'b0;
        #1;
        chk_zero("reset");
        step(1'b1, 4'b1010, 1'b0);
        step(1'b1, 4'b1010, 1'b0);
        repeat (6) step(1'b0, 4'b1010, 1'b0);
        chk("warmup.s2_bin", int'(bus2.d_out_bin), 12);

        // Jump to zero (2-bit step) then clear the error.
        repeat (4) step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b0);

        // Counting walk with holds: latency, delta=1 then 0, full wrap 14->15->0.
        cnt = 0;
        repeat (32) begin
            cnt++;
            step(1'b0, to_gray(cnt), 1'b0);
            step(1'b0, to_gray(cnt), 1'b0);
        end
        repeat (3) step(1'b0, 4'b0000, 1'b0);

        // Step error 0000->0011, clear, then a violation landing on the clear edge.
        repeat (5) step(1'b0, 4'b0011, 1'b0);
        step(1'b0, 4'b0011, 1'b1);
        repeat (3) step(1'b0, 4'b0011, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b0);

        // Random Gray walk with holds, stray clears and occasional illegal jumps.
        cnt = 0;
        repeat (300) begin
            int   r;
            ptr_t v;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                cnt++;
                v = to_gray(cnt);
            end else if (r < 95) begin
                v = to_gray(cnt);
            end else begin
                v   = ptr_t'($urandom);
                cnt = int'(to_bin[v]);
            end
            step(1'b0, v, ($urandom_range(0, 9) == 0));
        end

        // Mid-operation reset with bin=7 and a pending error.
        repeat (5) step(1'b0, 4'b0111, 1'b0);
        repeat (5) step(1'b0, 4'b0100, 1'b0);
        chk("midop.s2_bin", int'(bus2.d_out_bin), 7);
        chk("midop.s2_err", int'(bus2.step_err), 1);
        rst = 1'b1;
        #1;
        chk_zero("midop_reset");
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        repeat (8) step(1'b0, 4'b0100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
